// File: rtl/mole_hit_encoder_pkg.sv
// Shared constants and types for the mole switch-to-hit encoder.
package mole_pkg;

  localparam int NUM_HOLES = 9;
  localparam int IDX_W     = $clog2(NUM_HOLES);

  // One queued whack: which hole, and whether a mole was lit there.
  typedef struct packed {
    logic [IDX_W-1:0] index;
    logic             is_mole;
  } hit_event_t;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } enc_state_t;

endpackage

// File: rtl/mole_hit_encoder_debounce.sv
// Per-switch 2-flop synchroniser, debounce counter and toggle pulse.
module switch_debounce #(
  parameter int DEBOUNCE_CLKS = 2500000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic run,
  output logic tog
);

  localparam int CNT_W = $clog2(DEBOUNCE_CLKS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CLKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             meta;
  logic             sync;
  logic             stable;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous switch level into the clk domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= raw;
      sync <= meta;
    end
  end

  // Outside RUN, stable tracks the value sync is about to take, so on
  // entry to RUN stable already equals sync and no spurious toggle fires.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable <= 1'b0;
      cnt    <= '0;
      tog    <= 1'b0;
    end else begin
      tog <= 1'b0;
      if (!run) begin
        stable <= meta;
        cnt    <= '0;
      end else if (sync == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync;
        cnt    <= '0;
        tog    <= 1'b1;
      end else begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/mole_hit_encoder.sv
// Debounces hole switches, classifies each toggle against the lit moles,
// and queues hit events for the game FSM over a valid/ready handshake.
module mole_hit_encoder
  import mole_pkg::*;
#(
  parameter int NUM_HOLES     = mole_pkg::NUM_HOLES,
  parameter int DEBOUNCE_CLKS = 2500000,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_HOLES-1:0] switches,
  input  logic [NUM_HOLES-1:0] mole_positions,
  output logic                 hit_valid,
  input  logic                 hit_ready,
  output logic [IDX_W-1:0]     hit_index,
  output logic                 hit_is_mole,
  output logic                 overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

  enc_state_t           state;
  logic                 init_cnt;
  logic [NUM_HOLES-1:0] tog;
  logic [NUM_HOLES-1:0] pending;
  logic [NUM_HOLES-1:0] mole_flag;
  logic [NUM_HOLES-1:0] pending_nxt;
  logic [NUM_HOLES-1:0] flag_nxt;
  logic [NUM_HOLES-1:0] sel_onehot;
  logic [IDX_W-1:0]     sel_idx;
  logic                 sel_valid;
  logic                 sel_flag;
  logic                 drop;

  hit_event_t           mem [FIFO_DEPTH];
  logic [PTR_W:0]       wr_ptr;
  logic [PTR_W:0]       rd_ptr;
  logic                 empty;
  logic                 full;
  logic                 push;
  logic                 pop;

  // Hold INIT for two cycles while the synchronisers fill, then run.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= INIT;
      init_cnt <= 1'b0;
    end else if (state == INIT) begin
      init_cnt <= 1'b1;
      if (init_cnt) state <= RUN;
    end
  end

  for (genvar g = 0; g < NUM_HOLES; g++) begin : g_deb
    switch_debounce #(
      .DEBOUNCE_CLKS(DEBOUNCE_CLKS)
    ) u_deb (
      .clk  (clk),
      .reset(reset),
      .raw  (switches[g]),
      .run  (state == RUN),
      .tog  (tog[g])
    );
  end

  // Lowest-index pending hole wins the single push slot each cycle.
  always_comb begin
    sel_valid  = 1'b0;
    sel_idx    = '0;
    sel_onehot = '0;
    for (int i = NUM_HOLES - 1; i >= 0; i--) begin
      if (pending[i]) begin
        sel_valid  = 1'b1;
        sel_idx    = IDX_W'(i);
        sel_onehot = '0;
        sel_onehot[i] = 1'b1;
      end
    end
    sel_flag = |(sel_onehot & mole_flag);
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign pop   = hit_valid && hit_ready;
  assign push  = sel_valid && (!full || pop);

  // A toggle on an already-pending hole is dropped; the older event wins.
  always_comb begin
    pending_nxt = pending;
    flag_nxt    = mole_flag;
    if (push) pending_nxt = pending_nxt & ~sel_onehot;
    for (int i = 0; i < NUM_HOLES; i++) begin
      if (tog[i] && !pending[i]) begin
        pending_nxt[i] = 1'b1;
        flag_nxt[i]    = mole_positions[i];
      end
    end
    drop = |(tog & pending);
  end

  // Pending mask, captured mole flags and the sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending   <= '0;
      mole_flag <= '0;
      overflow  <= 1'b0;
    end else begin
      pending   <= pending_nxt;
      mole_flag <= flag_nxt;
      if (drop) overflow <= 1'b1;
    end
  end

  // Event FIFO; the extra pointer bit separates full from empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[PTR_W-1:0]] <= '{index: sel_idx, is_mole: sel_flag};
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  assign hit_valid   = !empty;
  assign hit_index   = mem[rd_ptr[PTR_W-1:0]].index;
  assign hit_is_mole = mem[rd_ptr[PTR_W-1:0]].is_mole;

endmodule

// File: tb/tb_mole_hit_encoder.sv
// Directed bench for mole_hit_encoder with a short debounce window.
module tb_mole_hit_encoder;
  import mole_pkg::*;

  localparam int NH = 9;
  localparam int DB = 4;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NH-1:0] switches = '0;
  logic [NH-1:0] mole_positions = '0;
  logic          hit_ready = 1'b0;
  logic          hit_valid;
  logic [IDX_W-1:0] hit_index;
  logic          hit_is_mole;
  logic          overflow;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int ev_idx[$];
  int ev_mole[$];
  int ev_cyc[$];

  mole_hit_encoder #(
    .NUM_HOLES(NH),
    .DEBOUNCE_CLKS(DB),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .switches(switches),
    .mole_positions(mole_positions),
    .hit_valid(hit_valid),
    .hit_ready(hit_ready),
    .hit_index(hit_index),
    .hit_is_mole(hit_is_mole),
    .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Record every transfer seen over n cycles (sampled 1ns after each edge).
  task automatic collect(input int n);
    repeat (n) begin
      if (hit_valid && hit_ready) begin
        ev_idx.push_back(int'(hit_index));
        ev_mole.push_back(int'(hit_is_mole));
        ev_cyc.push_back(cyc);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_events();
    ev_idx.delete();
    ev_mole.delete();
    ev_cyc.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    switches = 9'h003;
    mole_positions = '0;
    hit_ready = 1'b1;
    step(3);
    n_checks++;
    if (hit_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", hit_valid); end
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step(1);
      n_checks++;
      if (hit_valid !== 1'b0) begin n_fail++; $display("FAIL reset_hold_valid cycle %0d: got %b expected 0", c, hit_valid); end
    end
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    n_checks++;
    if (hit_index !== '0) begin n_fail++; $display("FAIL reset_index: got %0d expected 0", hit_index); end
    n_checks++;
    if (hit_is_mole !== 1'b0) begin n_fail++; $display("FAIL reset_is_mole: got %b expected 0", hit_is_mole); end
  endtask

  task automatic test_single_hit();
    mole_positions = 9'h010;
    hit_ready = 1'b1;
    switches[4] = 1'b1;
    for (int e = 1; e <= DB + 3; e++) begin
      step(1);
      n_checks++;
      if (hit_valid !== 1'b0) begin n_fail++; $display("FAIL latency_early edge %0d: got %b expected 0", e, hit_valid); end
    end
    step(1);
    n_checks++;
    if (hit_valid !== 1'b1) begin n_fail++; $display("FAIL latency_valid: got %b expected 1", hit_valid); end
    n_checks++;
    if (hit_index !== 4'd4) begin n_fail++; $display("FAIL single_index: got %0d expected 4", hit_index); end
    n_checks++;
    if (hit_is_mole !== 1'b1) begin n_fail++; $display("FAIL single_is_mole: got %b expected 1", hit_is_mole); end
    step(1);
    n_checks++;
    if (hit_valid !== 1'b0) begin n_fail++; $display("FAIL single_pulse: got %b expected 0", hit_valid); end
  endtask

  task automatic test_glitch();
    mole_positions = '0;
    hit_ready = 1'b1;
    clear_events();
    switches[2] = 1'b1;
    collect(3);
    switches[2] = 1'b0;
    collect(20);
    n_checks++;
    if (ev_idx.size() != 0) begin n_fail++; $display("FAIL glitch_ignored: got %0d events expected 0", ev_idx.size()); end
    clear_events();
    switches[2] = 1'b1;
    collect(10);
    switches[2] = 1'b0;
    collect(30);
    n_checks++;
    if (ev_idx.size() != 2) begin
      n_fail++; $display("FAIL long_pulse_count: got %0d events expected 2", ev_idx.size());
    end else begin
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (ev_idx[k] != 2 || ev_mole[k] != 0) begin
          n_fail++; $display("FAIL long_pulse_event %0d: got idx %0d mole %0d expected idx 2 mole 0", k, ev_idx[k], ev_mole[k]);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    int exp_idx[3] = '{1, 5, 7};
    mole_positions = '0;
    hit_ready = 1'b1;
    clear_events();
    switches = switches ^ 9'h0A2;
    collect(20);
    n_checks++;
    if (ev_idx.size() != 3) begin
      n_fail++; $display("FAIL simul_count: got %0d events expected 3", ev_idx.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (ev_idx[k] != exp_idx[k] || ev_mole[k] != 0) begin
          n_fail++; $display("FAIL simul_event %0d: got idx %0d mole %0d expected idx %0d mole 0", k, ev_idx[k], ev_mole[k], exp_idx[k]);
        end
      end
      for (int k = 1; k < 3; k++) begin
        n_checks++;
        if (ev_cyc[k] != ev_cyc[k-1] + 1) begin
          n_fail++; $display("FAIL simul_back_to_back %0d: got gap %0d expected 1", k, ev_cyc[k] - ev_cyc[k-1]);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [NH-1:0] lit;
    lit = 9'h005;
    hit_ready = 1'b0;
    mole_positions = lit;
    clear_events();
    switches = switches ^ 9'h03F;
    step(15);
    n_checks++;
    if (hit_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid: got %b expected 1", hit_valid); end
    n_checks++;
    if (hit_index !== 4'd0 || hit_is_mole !== 1'b1) begin
      n_fail++; $display("FAIL stall_head: got idx %0d mole %b expected idx 0 mole 1", hit_index, hit_is_mole);
    end
    step(5);
    n_checks++;
    if (hit_index !== 4'd0) begin n_fail++; $display("FAIL stall_head_hold: got %0d expected 0", hit_index); end
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL stall_no_overflow: got %b expected 0", overflow); end
    mole_positions = '0;
    switches[4] = ~switches[4];
    step(12);
    n_checks++;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL stall_overflow: got %b expected 1", overflow); end
    n_checks++;
    if (hit_valid !== 1'b1 || hit_index !== 4'd0) begin
      n_fail++; $display("FAIL stall_head_hold2: got valid %b idx %0d expected valid 1 idx 0", hit_valid, hit_index);
    end
    hit_ready = 1'b1;
    collect(20);
    n_checks++;
    if (ev_idx.size() != 6) begin
      n_fail++; $display("FAIL drain_count: got %0d events expected 6", ev_idx.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        n_checks++;
        if (ev_idx[k] != k || ev_mole[k] != int'(lit[k])) begin
          n_fail++; $display("FAIL drain_event %0d: got idx %0d mole %0d expected idx %0d mole %0d", k, ev_idx[k], ev_mole[k], k, lit[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    hit_ready = 1'b0;
    mole_positions = '0;
    switches = switches ^ 9'h140;
    step(15);
    n_checks++;
    if (hit_valid !== 1'b1) begin n_fail++; $display("FAIL mid_queued: got %b expected 1", hit_valid); end
    n_checks++;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_sticky: got %b expected 1", overflow); end
    #3;
    reset = 1'b1;
    #1;
    n_checks++;
    if (hit_valid !== 1'b0) begin n_fail++; $display("FAIL mid_async_valid: got %b expected 0", hit_valid); end
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL mid_async_overflow: got %b expected 0", overflow); end
    step(2);
    reset = 1'b0;
    hit_ready = 1'b1;
    clear_events();
    collect(30);
    n_checks++;
    if (ev_idx.size() != 0) begin n_fail++; $display("FAIL mid_no_events: got %0d events expected 0", ev_idx.size()); end
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_glitch();
    test_simultaneous();
    test_stall();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mole_hit_encoder.md
Name: mole_hit_encoder

Overview:
- Player-input end of the mole interface. The game FSM drives mole_positions to the LEDs; this block reads the switches back and decides which hole was whacked.
- Synchronises and debounces each hole switch, detects toggles in either direction, and classifies each toggle against mole_positions at detection time.
- Queues the resulting hit events in a small FIFO and hands them to the game FSM with a valid/ready handshake.

Parameters:
- NUM_HOLES, 9, number of holes/switches.
- DEBOUNCE_CLKS, 2500000, stable cycles required before a switch change is accepted (50 ms at 50 MHz). Must be ≥2.
- FIFO_DEPTH, 4, hit-event queue depth. Must be a power of 2 and ≥2.

Ports:
- clk  in  1  system clock (CLOCK_50).
- reset  in  1  asynchronous, active-high reset.
- switches  in  NUM_HOLES  raw, asynchronous switch levels (SW[8:0]).
- mole_positions  in  NUM_HOLES  current lit moles, from the FSM, synchronous to clk.
- hit_valid  out  1  FIFO head holds an event.
- hit_ready  in  1  consumer accepts the head this cycle.
- hit_index  out  IDX_W  hole number of the head event; IDX_W = $clog2(NUM_HOLES).
- hit_is_mole  out  1  1 means the hole was lit when the toggle was accepted.
- overflow  out  1  sticky flag: at least one event was dropped.

Behaviour:
- Reset (asynchronous):
  - Outputs: hit_valid=0, hit_index=0, hit_is_mole=0, overflow=0.
  - Internal: FIFO empty, pending mask=0, all debounce counters=0, state=INIT.
- Synchroniser: 2-flop synchroniser on each switch bit, giving sync[i].
- State INIT (2 cycles after reset release):
  - Counts while the synchroniser fills.
  - On the 2nd cycle, loads stable[i]=sync[i] for every i. No events are generated.
  - Then moves to RUN. Switches already up at reset therefore produce no spurious hit.
- State RUN, per switch:
  - When sync[i]!=stable[i], cnt[i] increments each cycle.
  - When sync[i]==stable[i], cnt[i] is cleared to 0. A glitch shorter than DEBOUNCE_CLKS is ignored.
  - When cnt[i]==DEBOUNCE_CLKS-1 and the mismatch persists, the block sets stable[i]=sync[i], clears cnt[i] and pulses tog[i] for 1 cycle.
  - Rising and falling toggles are both whacks.
- Classification:
  - On tog[i], pending[i] is set and mole_flag[i] is captured from mole_positions[i] in the same cycle.
  - If pending[i] is already set when tog[i] fires, the new event is dropped, the old pending event is kept, and overflow is set.
- Arbitration:
  - Each cycle, if the FIFO is not full (accounting for a same-cycle pop), the lowest-index set pending bit is pushed as {index, mole_flag} and that bit is cleared.
  - Only one push per cycle is allowed.
  - Simultaneous toggles on several holes are all kept and are serialised by ascending index.
- FIFO full: pending bits wait, with no loss. Simultaneous push and pop when full is allowed.
- Output handshake:
  - hit_valid = FIFO not empty. A transfer occurs when hit_valid && hit_ready.
  - hit_index and hit_is_mole are held stable while hit_valid && !hit_ready.
  - hit_ready while empty has no effect.
- Latency, uncontended, FIFO empty: hit_valid rises exactly DEBOUNCE_CLKS+4 clk edges after the first edge that samples the new switch level. This is 2 sync edges, DEBOUNCE_CLKS counting, 1 pending, 1 FIFO write.
- overflow is cleared only by reset.
- Reset mid-operation: everything returns to its reset value, pending and queued events are discarded, and INIT re-runs.

Decomposition:
- Package mole_pkg:
  - NUM_HOLES and IDX_W constants.
  - typedef struct packed {logic [IDX_W-1:0] index; logic is_mole;} hit_event_t.
  - typedef enum {INIT, RUN} enc_state_t.
- Sub-module switch_debounce: one per bit via generate. Contains the synchroniser, counter, stable register and tog pulse.
- Arbiter and FIFO: inline in the top of this block.

Test Plan (DEBOUNCE_CLKS=4, FIFO_DEPTH=4):
- Reset with SW=9'h003, hold 20 cycles → hit_valid stays 0, overflow=0.
- SW[4] 0→1 with mole_positions[4]=1, hit_ready=1 → hit_valid high exactly 8 edges later for 1 cycle; hit_index=4, hit_is_mole=1.
- SW[2] pulses high for 3 cycles, then returns → no event. A pulse held 10 cycles gives one event for toggle-up, then one for toggle-down.
- SW[7], SW[1], SW[5] toggle in the same cycle, mole_positions=0, hit_ready=1 → events on 3 consecutive cycles with indices 1, 5, 7 and hit_is_mole=0.
- hit_ready=0 with holes 0–5 toggled → FIFO holds indices 0–3 and pending holds 4,5. Head payload stays fixed at index 0. Toggle hole 4 again → overflow=1. Release ready → indices 0,1,2,3,4,5 in order, each once.
- Assert reset with 2 events queued → hit_valid=0 immediately (asynchronous), and no events after release.
